// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the adc_ctrl serial ADC sequencer: FSM state encoding
// and the counter width helper.
package adc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator for adc_ctrl: phase counter plus registered sclk,
// with single-cycle pulses marking the sample point and the end of each bit.
module adc_sclk_gen
  import adc_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic last,
  output logic sclk,
  output logic rise,
  output logic bit_end
);

  localparam int PW = cnt_w(2 * DIV);
  localparam logic [PW-1:0] PH_RISE = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_END  = PW'(2 * DIV - 1);

  logic [PW-1:0] phase;

  assign rise    = en && (phase == PH_RISE);
  assign bit_end = en && (phase == PH_END);

  // sclk falls at the start of every bit and returns high only after the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      sclk  <= 1'b1;
    end else if (start) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else if (bit_end) begin
      phase <= '0;
      sclk  <= last;
    end else if (en) begin
      phase <= phase + 1'b1;
      if (phase == PH_RISE) sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_ctrl.sv
// Periodic sequencer for a 12-bit serial ADC: drives cs_n/sclk, shifts in each
// frame and strobes done with the new sample. Optional macro ADC_CTRL_AVG_EN
// averages four conversions per output.
module adc_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int R      = 12,
  parameter int NBITS  = 16,
  parameter int DIV    = 4,
  parameter int PERIOD = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_en,
  input  logic         sdata,
  output logic         cs_n,
  output logic         sclk,
  output logic [R-1:0] sample,
  output logic         done,
  output logic         busy
);

  localparam int FRAME = NBITS * 2 * DIV;
  localparam bit B2B   = (PERIOD - 1) <= (FRAME + 1);
  localparam int BW    = cnt_w(NBITS);
  localparam int PCW   = cnt_w(PERIOD);

  state_t         state;
  logic [BW-1:0]  bit_cnt;
  logic [PCW-1:0] pcnt;
  logic [R-1:0]   sreg;
  logic           start, conv, last, rise, bit_end, frame_end;

  assign conv      = (state == CONV);
  assign last      = (bit_cnt == BW'(NBITS - 1));
  assign frame_end = bit_end && last;

  always_comb begin
    start = 1'b0;
    case (state)
      IDLE:    start = start_en;
      DONE:    start = start_en && B2B;
      WAIT:    start = start_en && (pcnt == PCW'(PERIOD - 1));
      default: start = 1'b0;
    endcase
  end

  adc_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (conv),
    .last    (last),
    .sclk    (sclk),
    .rise    (rise),
    .bit_end (bit_end)
  );

  // Only the final R bits shifted in survive, which drops the leading zeros.
  always_ff @(posedge clk) begin
    if (rise) sreg <= {sreg[R-2:0], sdata};
  end

`ifdef ADC_CTRL_AVG_EN
  logic [R+1:0] acc;
  logic [1:0]   acnt;
  logic [R+1:0] acc_sum;
  logic         enter_idle;

  assign acc_sum    = acc + {2'b00, sreg};
  assign enter_idle = !start_en && (state == DONE || state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      acnt <= '0;
    end else if (enter_idle) begin
      acc  <= '0;
      acnt <= '0;
    end else if (frame_end) begin
      acc  <= (acnt == 2'd3) ? '0 : acc_sum;
      acnt <= acnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sample  <= '0;
      bit_cnt <= '0;
      pcnt    <= '0;
    end else begin
      done <= 1'b0;
      if (pcnt != PCW'(PERIOD - 1)) pcnt <= pcnt + 1'b1;
      if (start) begin
        state   <= CONV;
        cs_n    <= 1'b0;
        busy    <= 1'b1;
        pcnt    <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          CONV: begin
            if (frame_end) begin
              state   <= DONE;
              cs_n    <= 1'b1;
              busy    <= 1'b0;
              bit_cnt <= '0;
`ifdef ADC_CTRL_AVG_EN
              if (acnt == 2'd3) begin
                sample <= acc_sum[R+1:2];
                done   <= 1'b1;
              end
`else
              sample <= sreg;
              done   <= 1'b1;
`endif
            end else if (bit_end) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          DONE:    state <= start_en ? WAIT : IDLE;
          WAIT:    if (!start_en) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_ctrl.sv
// Self-checking bench for adc_ctrl: serial ADC models feed queued frames into a
// PERIOD=5000 instance and a back-to-back PERIOD=100 instance.
module tb_adc_ctrl;

  localparam int R         = 12;
  localparam int NB        = 16;
  localparam int DIV       = 4;
  localparam int FRAME_LEN = NB * 2 * DIV;
  localparam int PER_A     = 5000;
  localparam int PER_B     = 100;

  typedef struct {
    logic [15:0] frame;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;

  logic        a_en = 1'b0, a_sdata = 1'b0, a_cs_n, a_sclk, a_done, a_busy;
  logic [11:0] a_sample;
  logic        b_en = 1'b0, b_sdata = 1'b0, b_cs_n, b_sclk, b_done, b_busy;
  logic [11:0] b_sample;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_ctrl #(.R(R), .NBITS(NB), .DIV(DIV), .PERIOD(PER_A)) dut_a (
    .clk(clk), .rst(rst), .start_en(a_en), .sdata(a_sdata), .cs_n(a_cs_n),
    .sclk(a_sclk), .sample(a_sample), .done(a_done), .busy(a_busy));

  adc_ctrl #(.R(R), .NBITS(NB), .DIV(DIV), .PERIOD(PER_B)) dut_b (
    .clk(clk), .rst(rst), .start_en(b_en), .sdata(b_sdata), .cs_n(b_cs_n),
    .sclk(b_sclk), .sample(b_sample), .done(b_done), .busy(b_busy));

  // ADC models: present the next queued word MSB first, advancing after each sclk rise.
  logic [15:0] a_q[$], b_q[$];
  logic [15:0] a_word, b_word;
  int          a_idx, b_idx;

  always @(negedge a_cs_n) begin
    a_word  = (a_q.size() > 0) ? a_q.pop_front() : 16'h0000;
    a_idx   = 0;
    a_sdata = a_word[15];
  end
  always @(posedge a_sclk) if (a_cs_n === 1'b0) begin
    a_idx++;
    if (a_idx < 16) a_sdata = a_word[15-a_idx];
  end

  always @(negedge b_cs_n) begin
    b_word  = (b_q.size() > 0) ? b_q.pop_front() : 16'h0000;
    b_idx   = 0;
    b_sdata = b_word[15];
  end
  always @(posedge b_sclk) if (b_cs_n === 1'b0) begin
    b_idx++;
    if (b_idx < 16) b_sdata = b_word[15-b_idx];
  end

  // Reference: the ADC word modulo 2^R is the result; averaging sums four and truncates.
  function automatic logic [11:0] model_sample(input logic [15:0] frame);
    return 12'(int'(frame) % (1 << R));
  endfunction

  function automatic logic [11:0] model_avg(input logic [15:0] f0, input logic [15:0] f1,
                                            input logic [15:0] f2, input logic [15:0] f3);
    int s;
    s = int'(model_sample(f0)) + int'(model_sample(f1)) + int'(model_sample(f2))
      + int'(model_sample(f3));
    return 12'(s / 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Follow one frame on dut_a: wait for cs_n fall, measure it, check the done cycle.
  task automatic frame_a(input logic [11:0] exp, input bit exp_done, input int drop_at,
                         output int fall);
    int   n, rises;
    bit   ok, stray;
    logic prev_sclk;
    n = 0;
    stray = 1'b0;
    while (a_cs_n !== 1'b0 && n < 6000) begin
      if (a_done !== 1'b0) stray = 1'b1;
      @(negedge clk);
      n++;
    end
    check("no_stray_done", stray, 1'b0);
    if (a_cs_n !== 1'b0) begin
      nvec++;
      nbad++;
      $display("FAIL cs_fall_timeout: cs_n=%b after %0d cycles, required 0", a_cs_n, n);
      fall = -1;
      return;
    end
    fall = cyc;
    n = 0;
    rises = 0;
    ok = 1'b1;
    prev_sclk = a_sclk;
    while (a_cs_n === 1'b0 && n < 300) begin
      if (a_done !== 1'b0 || a_busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
      n++;
      if (n == drop_at) a_en = 1'b0;
      if (a_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = a_sclk;
    end
    check("cs_low_len", n, FRAME_LEN);
    check("sclk_rises", rises, NB);
    check("busy_in_frame", ok, 1'b1);
    check("done_after_cs_rise", a_done, exp_done);
    check("sclk_idle_high", a_sclk, 1'b1);
    if (exp_done) check("sample", a_sample, exp);
    @(negedge clk);
    check("done_single", a_done, 1'b0);
  endtask

  initial begin
    vec_t        tbl[6];
    int          fall, prev_fall, n;
    bit          ok;
    logic [11:0] prev_exp;
    logic [15:0] g[4];

    tbl[0] = '{16'h0ABC, 12'hABC};
    tbl[1] = '{16'h0FFF, 12'hFFF};
    tbl[2] = '{16'h0000, 12'h000};
    tbl[3] = '{16'hF123, 12'h123};
    for (int i = 4; i < 6; i++) begin
      tbl[i].frame = 16'($urandom);
      tbl[i].exp   = model_sample(tbl[i].frame);
    end

    repeat (3) @(negedge clk);
    check("rst_cs_n", a_cs_n, 1'b1);
    check("rst_sclk", a_sclk, 1'b1);
    check("rst_sample", a_sample, 12'h000);
    check("rst_done", a_done, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (a_cs_n !== 1'b1 || a_sclk !== 1'b1 || a_done !== 1'b0 || a_sample !== 12'h000)
        ok = 1'b0;
    end
    check("idle_hold", ok, 1'b1);

`ifndef ADC_CTRL_AVG_EN
    // Periodic conversions through the vector table.
    for (int i = 0; i < 6; i++) a_q.push_back(tbl[i].frame);
    a_en = 1'b1;
    prev_fall = 0;
    prev_exp = 12'h000;
    for (int i = 0; i < 6; i++) begin
      frame_a(tbl[i].exp, 1'b1, -1, fall);
      if (i > 0) check("period", fall - prev_fall, PER_A);
      prev_fall = fall;
      prev_exp = tbl[i].exp;
    end
    check("sample_hold", a_sample, prev_exp);

    // start_en dropped mid-frame at bit 7: the frame still completes.
    a_q.push_back(16'h0555);
    frame_a(12'h555, 1'b1, 7 * 2 * DIV + 2, fall);
    ok = 1'b1;
    repeat (6000) begin
      @(negedge clk);
      if (a_cs_n !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) ok = 1'b0;
    end
    check("idle_after_drop", ok, 1'b1);
    check("sample_after_drop", a_sample, 12'h555);

    // Reset mid-frame aborts with no done.
    a_q.push_back(16'h0777);
    a_en = 1'b1;
    n = 0;
    while (a_cs_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("restart_fall", a_cs_n, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    a_en = 1'b0;
    #1;
    check("rst_async_cs_n", a_cs_n, 1'b1);
    check("rst_async_sclk", a_sclk, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_cs_n !== 1'b1) ok = 1'b0;
    end
    check("no_done_after_rst", ok, 1'b1);
    check("sample_cleared", a_sample, 12'h000);

    // Back-to-back frames on the short-period instance.
    for (int i = 0; i < 4; i++) begin
      g[i] = 16'($urandom);
      b_q.push_back(g[i]);
    end
    b_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (b_cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      check("b_fall", b_cs_n, 1'b0);
      if (i == 3) b_en = 1'b0;
      n = 0;
      while (b_cs_n === 1'b0 && n < 300) begin @(negedge clk); n++; end
      check("b_cs_low_len", n, FRAME_LEN);
      check("b_done", b_done, 1'b1);
      check("b_sample", b_sample, model_sample(g[i]));
      @(negedge clk);
      check(i < 3 ? "b_b2b_fall" : "b_stop", b_cs_n, (i < 3) ? 1'b0 : 1'b1);
    end
`else
    // Averaging: done only on every fourth conversion.
    g[0] = 16'h0100; g[1] = 16'h0101; g[2] = 16'h0102; g[3] = 16'h0104;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) a_q.push_back(g[i]);
      a_en = 1'b1;
      for (int i = 0; i < 4; i++)
        frame_a(model_avg(g[0], g[1], g[2], g[3]), i == 3, -1, fall);
      for (int i = 0; i < 4; i++) g[i] = 16'($urandom);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
